iccm_prog_loader: RTL

- Boot-time loader upstream of the instruction-memory wrapper.
- Receives a byte stream (UART RX side) and assembles little-endian 32-bit words.
- Writes those words into ICCM over the wrapper's req/we/wmask/addr/wdata port, holding the core in reset until loading completes.
- After completion, passes the core's instruction-fetch requests through to the same memory port, read-only.

---
 rtl/iccm_prog_loader_if.sv | 33 +++
 rtl/iccm_prog_loader.sv | 119 +++++++++++
 2 files changed

// File: rtl/iccm_prog_loader_if.sv
// Byte-stream, core-fetch and ICCM port bundle for the boot loader.
// slave is the loader's view; master is the surrounding system's view.
interface iccm_prog_loader_if #(
  parameter int ADDR_WIDTH = 12
);
  logic [7:0]            rx_data;
  logic                  rx_valid;
  logic                  rx_ready;
  logic                  core_req;
  logic [ADDR_WIDTH-1:0] core_addr;
  logic [31:0]           core_rdata;
  logic                  core_rvalid;
  logic                  core_rst_n;
  logic                  mem_req;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_wdata;
  logic [3:0]            mem_wmask;
  logic                  mem_we;
  logic [31:0]           mem_rdata;
  logic                  mem_rvalid;

  modport slave (
    input  rx_data, rx_valid, core_req, core_addr, mem_rdata, mem_rvalid,
    output rx_ready, core_rdata, core_rvalid, core_rst_n,
           mem_req, mem_addr, mem_wdata, mem_wmask, mem_we
  );

  modport master (
    output rx_data, rx_valid, core_req, core_addr, mem_rdata, mem_rvalid,
    input  rx_ready, core_rdata, core_rvalid, core_rst_n,
           mem_req, mem_addr, mem_wdata, mem_wmask, mem_we
  );
endinterface

// File: rtl/iccm_prog_loader.sv
// Boot loader: byte stream -> LE words -> ICCM writes, then core fetch passthrough (0 added latency).
// Backpressure: rx_ready low during the write cycle and once done/errored; core port read-only after load.
module iccm_prog_loader #(
  parameter int ADDR_WIDTH     = 12,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                  clock,
  input  logic                  reset,
  iccm_prog_loader_if.slave     bus,
  output logic                  load_done,
  output logic                  load_err,
  output logic [ADDR_WIDTH:0]   words_loaded
);
  typedef enum logic [2:0] {CNT_LO, CNT_HI, DATA, WRITE, DONE, ERROR} state_t;

  localparam int                TW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [16:0]       CAPACITY = 17'(2 ** ADDR_WIDTH);
  localparam logic [ADDR_WIDTH:0] ONE_W  = 1;

  state_t                state, next_state;
  logic [15:0]           count;
  logic [1:0]            byte_idx;
  logic [23:0]           asm_bytes;
  logic [TW-1:0]         idle_cnt;
  logic                  rx_ready_q, wr_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           wdata_q;

  logic                  xfer, mid_frame, timed_out, last_word;
  logic [16:0]           frame_n;
  logic                  rx_ready_d, wr_d, done_d, err_d;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic [31:0]           wdata_d;

  assign xfer      = bus.rx_valid && rx_ready_q;
  assign mid_frame = (state == CNT_HI) || (state == DATA);
  assign timed_out = mid_frame && !xfer && (idle_cnt == TW'(TIMEOUT_CYCLES - 1));
  assign frame_n   = {1'b0, bus.rx_data, count[7:0]};
  assign last_word = (17'(words_loaded) + 17'd1) == {1'b0, count};

  always_ff @(posedge clock) begin
    if (!reset) state <= CNT_LO;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      CNT_LO: if (xfer) next_state = CNT_HI;
      CNT_HI: begin
        if (xfer) begin
          if (frame_n == 17'd0)         next_state = DONE;
          else if (frame_n > CAPACITY)  next_state = ERROR;
          else                          next_state = DATA;
        end else if (timed_out) begin
          next_state = ERROR;
        end
      end
      DATA: begin
        if (xfer && byte_idx == 2'd3) next_state = WRITE;
        else if (timed_out)           next_state = ERROR;
      end
      WRITE:   next_state = last_word ? DONE : DATA;
      default: next_state = state;
    endcase
  end

  // Registered outputs are decoded from the next state so they line up with it.
  always_comb begin
    rx_ready_d = (next_state == CNT_LO) || (next_state == CNT_HI) || (next_state == DATA);
    wr_d       = (next_state == WRITE);
    addr_d     = wr_d ? words_loaded[ADDR_WIDTH-1:0] : '0;
    wdata_d    = wr_d ? {bus.rx_data, asm_bytes} : 32'h0;
    done_d     = (next_state == DONE);
    err_d      = (next_state == ERROR);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      rx_ready_q   <= 1'b0;
      wr_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= 32'h0;
      load_done    <= 1'b0;
      load_err     <= 1'b0;
      words_loaded <= '0;
      count        <= 16'h0;
      byte_idx     <= 2'd0;
      asm_bytes    <= 24'h0;
      idle_cnt     <= '0;
    end else begin
      rx_ready_q <= rx_ready_d;
      wr_q       <= wr_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      load_done  <= done_d;
      load_err   <= err_d;
      if (xfer && state == CNT_LO) count[7:0]  <= bus.rx_data;
      if (xfer && state == CNT_HI) count[15:8] <= bus.rx_data;
      if (xfer && state == DATA) begin
        asm_bytes <= {bus.rx_data, asm_bytes[23:8]};
        byte_idx  <= byte_idx + 2'd1;
      end
      if (state == WRITE) words_loaded <= words_loaded + ONE_W;
      idle_cnt <= (xfer || !mid_frame) ? '0 : idle_cnt + TW'(1);
    end
  end

  // Once done, the core owns the memory port; write fields are already zero.
  assign bus.rx_ready    = rx_ready_q;
  assign bus.core_rst_n  = load_done;
  assign bus.mem_req     = load_done ? bus.core_req  : wr_q;
  assign bus.mem_addr    = load_done ? bus.core_addr : addr_q;
  assign bus.mem_we      = wr_q;
  assign bus.mem_wmask   = {4{wr_q}};
  assign bus.mem_wdata   = wdata_q;
  assign bus.core_rdata  = load_done ? bus.mem_rdata : 32'h0;
  assign bus.core_rvalid = load_done && bus.mem_rvalid;
endmodule
